// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg -- shared definitions for the mem_responder slice.
//   SIZE encodings, RW encodings, FSM state type, and helpers that map an
//   access size onto the 4-lane big-endian storage port.
//   Lane 0 is the byte at the (aligned) access address and carries data bits [31:24].
package mem_resp_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // Byte lanes written for each access size.
  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001;
      SZ_HALF: lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Moves the low-order write data up so that its most significant byte
  // lands in lane 0 (big-endian placement).
  function automatic logic [31:0] place_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: place_wdata = {data[7:0], 24'h0};
      SZ_HALF: place_wdata = {data[15:0], 16'h0};
      default: place_wdata = data;
    endcase
  endfunction

  // Zero-extends the leading bytes of the storage read port.
  function automatic logic [31:0] extend_rdata(input logic [1:0] size, input logic [31:0] rdata);
    case (size)
      SZ_BYTE: extend_rdata = {24'h0, rdata[31:24]};
      SZ_HALF: extend_rdata = {16'h0, rdata[31:16]};
      default: extend_rdata = rdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// mem_resp_array -- DEPTH_BYTES x 8 storage with a 4-byte big-endian port.
//   clk      in   rising-edge clock (writes only; storage has no reset)
//   lane_we  in   4 byte-lane write enables, lane i writes mem[addr+i]
//   addr     in   AW-bit byte address, lanes wrap modulo DEPTH_BYTES
//   wdata    in   32-bit write data, lane i takes bits [31-8i -: 8]
//   rdata    out  32-bit combinational read {mem[addr] .. mem[addr+3]}
module mem_resp_array #(
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned AW          = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic [3:0]    lane_we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [7:0] mem [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (lane_we[i]) begin
        mem[addr + AW'(i)] <= wdata[31 - 8*i -: 8];
      end
    end
  end

  assign rdata = {mem[addr], mem[addr + AW'(1)], mem[addr + AW'(2)], mem[addr + AW'(3)]};

endmodule

// File: rtl/mem_responder.sv
// mem_responder -- wait-stated memory slave with a four-phase MOV/MOC handshake.
//   CLK       in   rising-edge clock
//   RST_N     in   asynchronous active-low reset (storage is not cleared)
//   MOV       in   memory operation valid from the control unit
//   RW        in   1=read, 0=write
//   SIZE      in   00=byte, 01=halfword, 10=word, 11=reserved (word)
//   ADDR      in   byte address, wrapped modulo DEPTH_BYTES
//   DATA_IN   in   write data (big-endian byte order in storage)
//   DATA_OUT  out  zero-extended read data, held between reads
//   MOC       out  memory operation complete
//   FAULT     out  only with `define MEM_RESP_FAULT_EN: misaligned or reserved-size
//                  access; it completes normally but writes nothing and leaves DATA_OUT
// Without MEM_RESP_FAULT_EN misaligned addresses are forced into alignment.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  SIZE,
  input  logic [31:0] ADDR,
  input  logic [31:0] DATA_IN,
  output logic [31:0] DATA_OUT,
  output logic        MOC
`ifdef MEM_RESP_FAULT_EN
  ,
  output logic        FAULT
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  mem_state_t    state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          start, enter_done;

  logic          rw_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;

  logic          op_rw;
  logic [1:0]    op_size;
  logic [AW-1:0] op_addr;
  logic [31:0]   op_data;
  logic [AW-1:0] eff_addr;
  logic          op_fault;
  logic [3:0]    lane_we;
  logic [31:0]   rdata;

  logic          unused_addr_hi;
  assign unused_addr_hi = ^ADDR[31:AW];

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    start      = 1'b0;
    enter_done = 1'b0;
    case (state)
      IDLE: begin
        if (MOV) begin
          start = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = DONE;
            enter_done = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CW'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (!MOV) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt <= CW'(1)) begin
          state_next = DONE;
          cnt_next   = '0;
          enter_done = 1'b1;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      DONE: begin
        if (!MOV) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // With zero wait states the latch edge is also the completion edge, so the
  // operands come straight from the inputs while still in IDLE.
  always_comb begin
    if (state == IDLE) begin
      op_rw   = RW;
      op_size = SIZE;
      op_addr = ADDR[AW-1:0];
      op_data = DATA_IN;
    end else begin
      op_rw   = rw_q;
      op_size = size_q;
      op_addr = addr_q;
      op_data = data_q;
    end
  end

  always_comb begin
    case (op_size)
      SZ_BYTE: eff_addr = op_addr;
      SZ_HALF: eff_addr = {op_addr[AW-1:1], 1'b0};
      default: eff_addr = {op_addr[AW-1:2], 2'b00};
    endcase
  end

`ifdef MEM_RESP_FAULT_EN
  assign op_fault = (op_size == SZ_RSVD) ||
                    ((op_size == SZ_HALF) && op_addr[0]) ||
                    ((op_size == SZ_WORD) && (op_addr[1:0] != 2'b00));
`else
  assign op_fault = 1'b0;
`endif

  assign lane_we = (enter_done && (op_rw == RW_WRITE) && !op_fault) ? lane_mask(op_size) : 4'b0000;

  mem_resp_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .AW          (AW)
  ) u_array (
    .clk     (CLK),
    .lane_we (lane_we),
    .addr    (eff_addr),
    .wdata   (place_wdata(op_size, op_data)),
    .rdata   (rdata)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      cnt      <= '0;
      rw_q     <= RW_READ;
      size_q   <= SZ_BYTE;
      addr_q   <= '0;
      data_q   <= '0;
      DATA_OUT <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (start) begin
        rw_q   <= RW;
        size_q <= SIZE;
        addr_q <= ADDR[AW-1:0];
        data_q <= DATA_IN;
      end
      if (enter_done && (op_rw == RW_READ) && !op_fault) begin
        DATA_OUT <= extend_rdata(op_size, rdata);
      end
    end
  end

  assign MOC = (state == DONE);

`ifdef MEM_RESP_FAULT_EN
  logic fault_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fault_q <= 1'b0;
    end else if (enter_done) begin
      fault_q <= op_fault;
    end else if ((state == DONE) && !MOV) begin
      fault_q <= 1'b0;
    end
  end

  assign FAULT = fault_q;
`endif

endmodule
